// File: rtl/shader_mem_server.sv
// Memory-side responder for the GPU fetch port. Loads a shader image from a valid/ready stream,
// zero-fills the unused tail, then releases the GPU and serves registered 1-cycle fetches.
module shader_mem_server #(
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 11
) (
  input  logic              clk,
  input  logic              KEY0,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [15:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] input_addr,
  output logic [15:0]       data_input,
  output logic              mem_ready,
  output logic              gpu_rst_n,
  output logic [CNT_W-1:0]  words_loaded,
  output logic              overflow_err
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DATA_DEPTH);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DATA_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              ovf_q, ovf_d;
  logic              run_q, run_d;
  logic [15:0]       data_q, data_d;

  logic [15:0]       mem [DATA_DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [15:0]       mem_wdata;
  logic [CNT_W-1:0]  words_inc;
  logic              addr_ok;

  assign load_ready = (state_q == LOAD);
  assign words_inc  = words_q + CNT_W'(1);
  // Upper address bits must be zero so out-of-range fetches never alias into the store.
  assign addr_ok    = (input_addr[ADDR_W-1:AW] == '0);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    words_d   = words_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;
    mem_wdata = load_data;
    unique case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          words_d = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + AW'(1);
          words_d = words_inc;
          if (load_last) begin
            state_d = (words_inc == DEPTH_CNT) ? RUN : CLEAR;
          end else if (words_inc == DEPTH_CNT) begin
            ovf_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        wptr_d    = wptr_q + AW'(1);
        if (wptr_q == LAST_ADDR) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    run_d  = (state_d == RUN);
    data_d = (state_q == RUN && addr_ok) ? mem[input_addr[AW-1:0]] : 16'h0;
  end

  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
      data_q  <= data_d;
    end
  end

  // Store has no reset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_input   = data_q;
  assign mem_ready    = run_q;
  assign gpu_rst_n    = run_q;
  assign words_loaded = words_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_shader_mem_server.sv
// Self-checking bench for shader_mem_server: directed loads plus a fetch scoreboard
// whose monitor compares each registered fetch result against the queued expectation.
module tb_shader_mem_server;

   localparam int DATA_DEPTH = 1024;
   localparam int ADDR_W     = 20;
   localparam int CNT_W      = 11;

   logic              clk;
   logic              KEY0;
   logic              load_start;
   logic              load_valid;
   logic [15:0]       load_data;
   logic              load_last;
   logic              load_ready;
   logic [ADDR_W-1:0] input_addr;
   logic [15:0]       data_input;
   logic              mem_ready;
   logic              gpu_rst_n;
   logic [CNT_W-1:0]  words_loaded;
   logic              overflow_err;

   logic              fetch_req;
   logic              fetch_pend;
   logic [15:0]       exp_q[$];
   int                checks;
   int                errors;

   shader_mem_server #(
      .DATA_DEPTH(DATA_DEPTH),
      .ADDR_W    (ADDR_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .KEY0        (KEY0),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .input_addr  (input_addr),
      .data_input  (data_input),
      .mem_ready   (mem_ready),
      .gpu_rst_n   (gpu_rst_n),
      .words_loaded(words_loaded),
      .overflow_err(overflow_err)
   );

   // Free-running clock, posedge every 10 time units starting at t=5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one fetch at the current negedge and queues the value the next edge should register.
   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [15:0] exp);
      input_addr = addr;
      fetch_req  = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      fetch_req  = 1'b0;
   endtask

   // Monitor: a fetch issued before an edge has its result on data_input at the following negedge.
   always @(posedge clk) fetch_pend <= fetch_req;

   always @(negedge clk) begin
      if (fetch_pend) begin
         if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected", 32'(data_input), 32'hDEAD_BEEF);
         end else begin
            checkOutput("fetch", 32'(data_input), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic startLoad();
      load_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic sendWord(input logic [15:0] d, input logic last, input int gap);
      load_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         @(negedge clk);
      end
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Counts edges until mem_ready rises; a missing rise within the bound is itself a failure.
   task automatic waitReady(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!mem_ready && n < 2000) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_clear_cycles"}, 32'(n), 32'(exp_cycles));
      checkOutput({name, "_mem_ready"}, 32'(mem_ready), 32'd1);
      checkOutput({name, "_gpu_rst_n"}, 32'(gpu_rst_n), 32'd1);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      KEY0       = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      input_addr = '0;
      fetch_req  = 1'b0;
      fetch_pend = 1'b0;

      // Power-on reset values.
      #7;
      checkOutput("rst_data_input", 32'(data_input), 32'd0);
      checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
      checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
      checkOutput("rst_gpu_rst_n", 32'(gpu_rst_n), 32'd0);
      checkOutput("rst_words", 32'(words_loaded), 32'd0);
      checkOutput("rst_ovf", 32'(overflow_err), 32'd0);
      @(negedge clk);
      KEY0 = 1'b1;
      @(negedge clk);
      checkOutput("idle_load_ready", 32'(load_ready), 32'd0);

      // T2: 224 words of 3i+1, then 800 zero-fill cycles.
      $display("[TB] T2 partial image load");
      startLoad();
      checkOutput("t2_load_ready", 32'(load_ready), 32'd1);
      for (int i = 0; i < 224; i++) sendWord(16'(3 * i + 1), (i == 223), 0);
      checkOutput("t2_words", 32'(words_loaded), 32'd224);
      checkOutput("t2_clear_ready", 32'(load_ready), 32'd0);
      checkOutput("t2_clear_mem_ready", 32'(mem_ready), 32'd0);
      waitReady("t2", 800);
      applyStimulus(20'd5, 16'd16);
      applyStimulus(20'd223, 16'd670);
      applyStimulus(20'd224, 16'd0);
      applyStimulus(20'd500, 16'd0);
      applyStimulus(20'h00400, 16'd0);
      applyStimulus(20'd0, 16'd1);

      // T1: asynchronous reset while running clears outputs immediately.
      $display("[TB] T1 reset mid-run");
      input_addr = 20'd5;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t1_pre_data", 32'(data_input), 32'd16);
      #2;
      KEY0 = 1'b0;
      #1;
      checkOutput("t1_data_input", 32'(data_input), 32'd0);
      checkOutput("t1_mem_ready", 32'(mem_ready), 32'd0);
      checkOutput("t1_gpu_rst_n", 32'(gpu_rst_n), 32'd0);
      checkOutput("t1_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      KEY0 = 1'b1;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      checkOutput("t1_idle_ready", 32'(load_ready), 32'd0);
      checkOutput("t1_idle_mem_ready", 32'(mem_ready), 32'd0);

      // T3: 16 words with random gaps; a load_start alongside word 5 must be ignored.
      $display("[TB] T3 backpressure gaps");
      startLoad();
      for (int i = 0; i < 16; i++) begin
         if (i == 5) load_start = 1'b1;
         sendWord(16'hA000 + 16'(i), (i == 15), int'($urandom_range(1, 3)));
         load_start = 1'b0;
      end
      checkOutput("t3_words", 32'(words_loaded), 32'd16);
      waitReady("t3", 1008);
      for (int i = 0; i < 16; i++) applyStimulus(20'(i), 16'hA000 + 16'(i));
      applyStimulus(20'd16, 16'd0);

      // T4: full-depth image without load_last.
      $display("[TB] T4 overflow");
      startLoad();
      for (int i = 0; i < DATA_DEPTH; i++) sendWord(16'(i) ^ 16'h5A5A, 1'b0, 0);
      checkOutput("t4_ovf", 32'(overflow_err), 32'd1);
      checkOutput("t4_words", 32'(words_loaded), 32'd1024);
      waitReady("t4", 0);
      applyStimulus(20'd0, 16'h5A5A);
      applyStimulus(20'd1023, 16'h59A5);
      applyStimulus(20'h00400, 16'd0);
      applyStimulus(20'hFFFFF, 16'd0);

      // T5: reset during zero-fill, then a clean 10-word reload.
      $display("[TB] T5 reset during clear");
      startLoad();
      checkOutput("t5_ovf_cleared", 32'(overflow_err), 32'd0);
      for (int i = 0; i < 10; i++) sendWord(16'hBEE0 + 16'(i), (i == 9), 0);
      repeat (5) @(negedge clk);
      #2;
      KEY0 = 1'b0;
      #1;
      checkOutput("t5_gpu_rst_n", 32'(gpu_rst_n), 32'd0);
      checkOutput("t5_mem_ready", 32'(mem_ready), 32'd0);
      @(negedge clk);
      KEY0 = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("t5_idle_ready", 32'(load_ready), 32'd0);
      checkOutput("t5_idle_mem_ready", 32'(mem_ready), 32'd0);
      startLoad();
      for (int i = 0; i < 10; i++) sendWord(16'h1000 + 16'(i), (i == 9), 0);
      checkOutput("t5_words", 32'(words_loaded), 32'd10);
      waitReady("t5", 1014);
      applyStimulus(20'd9, 16'h1009);
      applyStimulus(20'd10, 16'd0);

      // T6: load_start while running drops the GPU and blanks fetches until the reload completes.
      $display("[TB] T6 reload from run");
      load_start = 1'b1;
      applyStimulus(20'd3, 16'h1003);
      load_start = 1'b0;
      checkOutput("t6_mem_ready", 32'(mem_ready), 32'd0);
      checkOutput("t6_gpu_rst_n", 32'(gpu_rst_n), 32'd0);
      checkOutput("t6_load_ready", 32'(load_ready), 32'd1);
      applyStimulus(20'd3, 16'd0);
      for (int i = 0; i < 4; i++) sendWord(16'h2000 + 16'(i), (i == 3), 0);
      checkOutput("t6_words", 32'(words_loaded), 32'd4);
      applyStimulus(20'd2, 16'd0);
      waitReady("t6", 1019);
      applyStimulus(20'd2, 16'h2002);
      applyStimulus(20'd4, 16'd0);

      @(negedge clk);
      checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
